// File: rtl/cpri_wr_arbiter.sv
// Round-robin block arbiter sharing the CPRI TX write port between NREQ packers.
// Define CPRI_ARB_WDOG_EN to add the XFER stall watchdog (limit WDOG_CYC).
module cpri_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int DW       = 64,
   parameter int AW       = 7,
   parameter int BLK_LEN  = 96,
   parameter int GAP_CYC  = 1,
   parameter int WDOG_CYC = 256
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_tx_enable,
   input  logic [NREQ-1:0]          i_req,
   output logic [NREQ-1:0]          o_gnt,
   input  logic [NREQ-1:0]          i_wen,
   input  logic [NREQ*DW-1:0]       i_wdata,
   input  logic [NREQ-1:0]          i_wlast,
   output logic                     o_cpri_wen,
   output logic [AW-1:0]            o_cpri_waddr,
   output logic [DW-1:0]            o_cpri_wdata,
   output logic                     o_cpri_wlast,
   output logic [$clog2(NREQ)-1:0]  o_gnt_id,
   output logic                     o_busy,
   output logic                     o_err_len,
   output logic [15:0]              o_err_cnt
);

   localparam int IW = $clog2(NREQ);

   generate
      if (BLK_LEN > 2**AW || GAP_CYC > 15 || WDOG_CYC < 1) begin : g_bad_cfg
         $error("cpri_wr_arbiter: invalid parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]     gnt_id_q, gnt_id_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [3:0]        gap_q, gap_d;
   logic              wen_q, wen_d;
   logic [AW-1:0]     waddr_q, waddr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic              wlast_q, wlast_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [15:0]       err_cnt_q, err_cnt_d;

`ifdef CPRI_ARB_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0]     wdog_q, wdog_d;
`endif

   logic              win_vld;
   logic [IW-1:0]     win_id;
   int                arb_idx;
   logic              sel_wen;
   logic              sel_wlast;
   logic [DW-1:0]     sel_wdata;
   logic              last_word;
   state_t            end_state;

   // Search starts at ptr_q, which is one past the previous winner.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      arb_idx = 0;
      for (int i = 0; i < NREQ; i++) begin
         arb_idx = int'(ptr_q) + i;
         if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
         if (!win_vld && i_req[arb_idx]) begin
            win_vld = 1'b1;
            win_id  = IW'(arb_idx);
         end
      end
   end

   assign sel_wen   = i_wen[gnt_id_q];
   assign sel_wlast = i_wlast[gnt_id_q];
   assign sel_wdata = i_wdata[int'(gnt_id_q)*DW +: DW];
   assign last_word = (cnt_q == AW'(BLK_LEN - 1));
   assign end_state = (GAP_CYC == 0) ? S_IDLE : S_GAP;

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      wen_d    = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wlast_d  = 1'b0;
      err_d    = 1'b0;
`ifdef CPRI_ARB_WDOG_EN
      wdog_d   = wdog_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (i_tx_enable && win_vld) begin
               gnt_d    = NREQ'(1) << win_id;
               gnt_id_d = win_id;
               ptr_d    = (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
               cnt_d    = '0;
               state_d  = S_GRANT;
            end
         end
         S_GRANT: begin
            state_d = S_XFER;
`ifdef CPRI_ARB_WDOG_EN
            wdog_d  = '0;
`endif
         end
         S_XFER: begin
            if (sel_wen) begin
               wen_d   = 1'b1;
               waddr_d = cnt_q;
               wdata_d = sel_wdata;
               wlast_d = sel_wlast | last_word;
               cnt_d   = cnt_q + 1'b1;
`ifdef CPRI_ARB_WDOG_EN
               wdog_d  = '0;
`endif
               // Mismatch of wlast vs. position flags short or long blocks.
               if (sel_wlast || last_word) begin
                  err_d   = sel_wlast ^ last_word;
                  gnt_d   = '0;
                  gap_d   = '0;
                  state_d = end_state;
               end
            end
`ifdef CPRI_ARB_WDOG_EN
            else if (wdog_q == WW'(WDOG_CYC - 1)) begin
               wen_d   = 1'b1;
               waddr_d = cnt_q;
               wdata_d = '0;
               wlast_d = 1'b1;
               err_d   = 1'b1;
               gnt_d   = '0;
               gap_d   = '0;
               state_d = end_state;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         S_GAP: begin
            if (gap_q == 4'(GAP_CYC - 1)) state_d = S_IDLE;
            else gap_d = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d    = (state_d != S_IDLE);
      err_cnt_d = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wlast_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
`ifdef CPRI_ARB_WDOG_EN
         wdog_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wlast_q   <= wlast_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
`ifdef CPRI_ARB_WDOG_EN
         wdog_q    <= wdog_d;
`endif
      end
   end

   assign o_gnt        = gnt_q;
   assign o_gnt_id     = gnt_id_q;
   assign o_cpri_wen   = wen_q;
   assign o_cpri_waddr = waddr_q;
   assign o_cpri_wdata = wdata_q;
   assign o_cpri_wlast = wlast_q;
   assign o_busy       = busy_q;
   assign o_err_len    = err_q;
   assign o_err_cnt    = err_cnt_q;

endmodule
